// File: rtl/ram_1w2r.sv
// rtl/ram_1w2r.sv - 1-write/2-read synchronous RAM with write buffer and read forwarding; optional power-on clear via RAM_1W2R_CLEAR_EN
module ram_1w2r #(
   parameter int DEEPTH = 8,
   parameter int WIDTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DEEPTH-1:0] write_addr,
   input  logic [WIDTH-1:0]  write_data,
   input  logic              write_EN,
   input  logic [DEEPTH-1:0] read_addr_A,
   input  logic [DEEPTH-1:0] read_addr_B,
   input  logic              read_EN_A,
   input  logic              read_EN_B,
   output logic [WIDTH-1:0]  read_data_A,
   output logic [WIDTH-1:0]  read_data_B,
   output logic              busy
);

   localparam int WORDS = 2**DEEPTH;

   logic [WIDTH-1:0]  mem [0:WORDS-1];

   logic              wb_valid;
   logic [DEEPTH-1:0] wb_addr;
   logic [WIDTH-1:0]  wb_data;

   logic              clearing;
   logic              wr_accept;
   logic [WIDTH-1:0]  fwd_a;
   logic [WIDTH-1:0]  fwd_b;

`ifdef RAM_1W2R_CLEAR_EN
   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   state_t            state_next;
   logic [DEEPTH-1:0] clr_cnt;
   logic [DEEPTH-1:0] clr_cnt_next;

   // Clear FSM state and sweep counter; reset always restarts the sweep at 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= clr_cnt_next;
      end
   end

   // Sweep every address once, then fall back to normal operation
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      if (state == CLEAR) begin
         clr_cnt_next = clr_cnt + DEEPTH'(1);
         if (clr_cnt == '1) begin
            state_next = IDLE;
         end
      end
   end

   assign clearing = (state == CLEAR);
`else
   assign clearing = 1'b0;
`endif

   assign busy      = clearing;
   // Writes arriving during the clear sweep are dropped
   assign wr_accept = write_EN & ~clearing;

   // Array update: clear sweep when enabled, otherwise drain the write buffer
   always_ff @(posedge clk) begin
`ifdef RAM_1W2R_CLEAR_EN
      if (clearing) begin
         mem[clr_cnt] <= '0;
      end else
`endif
      if (wb_valid) begin
         mem[wb_addr] <= wb_data;
      end
   end

   // Write buffer: capture the new write while the previous one commits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= wr_accept;
         if (wr_accept) begin
            wb_addr <= write_addr;
            wb_data <= write_data;
         end
      end
   end

   // Port A source select: incoming write beats buffer beats array
   always_comb begin
      fwd_a = mem[read_addr_A];
      if (wb_valid && (wb_addr == read_addr_A)) begin
         fwd_a = wb_data;
      end
      if (wr_accept && (write_addr == read_addr_A)) begin
         fwd_a = write_data;
      end
      if (clearing) begin
         fwd_a = '0;
      end
   end

   // Port B source select, resolved independently of port A
   always_comb begin
      fwd_b = mem[read_addr_B];
      if (wb_valid && (wb_addr == read_addr_B)) begin
         fwd_b = wb_data;
      end
      if (wr_accept && (write_addr == read_addr_B)) begin
         fwd_b = write_data;
      end
      if (clearing) begin
         fwd_b = '0;
      end
   end

   // Registered read outputs; each port holds its value when not enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data_A <= '0;
         read_data_B <= '0;
      end else begin
         if (read_EN_A) begin
            read_data_A <= fwd_a;
         end
         if (read_EN_B) begin
            read_data_B <= fwd_b;
         end
      end
   end

endmodule

// File: tb/tb_ram_1w2r.sv
// tb/tb_ram_1w2r.sv - scoreboard bench for ram_1w2r against a last-write-wins memory model
module tb_ram_1w2r;

   localparam int DEEPTH = 8;
   localparam int WIDTH  = 8;
   localparam int WORDS  = 2**DEEPTH;

   logic              clk = 1'b0;
   logic              rst;
   logic [DEEPTH-1:0] write_addr;
   logic [WIDTH-1:0]  write_data;
   logic              write_EN;
   logic [DEEPTH-1:0] read_addr_A;
   logic [DEEPTH-1:0] read_addr_B;
   logic              read_EN_A;
   logic              read_EN_B;
   logic [WIDTH-1:0]  read_data_A;
   logic [WIDTH-1:0]  read_data_B;
   logic              busy;

   ram_1w2r #(.DEEPTH(DEEPTH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_EN    (write_EN),
      .read_addr_A (read_addr_A),
      .read_addr_B (read_addr_B),
      .read_EN_A   (read_EN_A),
      .read_EN_B   (read_EN_B),
      .read_data_A (read_data_A),
      .read_data_B (read_data_B),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             ca;
      logic [WIDTH-1:0] a;
      logic             cb;
      logic [WIDTH-1:0] b;
      logic             bz;
   } exp_t;

   exp_t q[$];

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: memory holds the newest write immediately
   logic [WIDTH-1:0]  mem_m [WORDS];
   logic              known [WORDS];
   logic              pend_v = 1'b0;
   logic [DEEPTH-1:0] pend_addr;
   logic [WIDTH-1:0]  pend_old;
   logic              pend_known;
   logic [WIDTH-1:0]  cur_a = '0;
   logic [WIDTH-1:0]  cur_b = '0;
   logic              ca = 1'b1;
   logic              cb = 1'b1;
   int                clear_left = 0;
   int                resets = 0;

   task automatic step(input logic r, input logic we, input logic [DEEPTH-1:0] wa,
                       input logic [WIDTH-1:0] wd, input logic ea, input logic [DEEPTH-1:0] aa,
                       input logic eb, input logic [DEEPTH-1:0] ab);
      exp_t e;
      @(negedge clk);
      rst = r; write_EN = we; write_addr = wa; write_data = wd;
      read_EN_A = ea; read_addr_A = aa; read_EN_B = eb; read_addr_B = ab;
      if (r) begin
         // An uncommitted write is lost on reset
         if (pend_v) begin
            mem_m[pend_addr] = pend_old;
            known[pend_addr] = pend_known;
         end
         pend_v = 1'b0;
         cur_a = '0; cur_b = '0; ca = 1'b1; cb = 1'b1;
`ifdef RAM_1W2R_CLEAR_EN
         for (int i = 0; i < WORDS; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b1;
         end
         clear_left = WORDS;
`endif
      end else if (clear_left > 0) begin
         clear_left--;
         pend_v = 1'b0;
         if (ea) begin cur_a = '0; ca = 1'b1; end
         if (eb) begin cur_b = '0; cb = 1'b1; end
      end else begin
         pend_v = 1'b0;
         if (we) begin
            pend_v     = 1'b1;
            pend_addr  = wa;
            pend_old   = mem_m[wa];
            pend_known = known[wa];
            mem_m[wa]  = wd;
            known[wa]  = 1'b1;
         end
         if (ea) begin cur_a = mem_m[aa]; ca = known[aa]; end
         if (eb) begin cur_b = mem_m[ab]; cb = known[ab]; end
      end
      e.ca = ca; e.a = cur_a; e.cb = cb; e.b = cur_b; e.bz = (clear_left > 0);
      q.push_back(e);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   function automatic logic [DEEPTH-1:0] rand_addr();
      int sel = $urandom_range(0, 3);
      if (sel < 2) return DEEPTH'($urandom_range(0, 3));
      if (sel == 2) return DEEPTH'($urandom_range(WORDS - 4, WORDS - 1));
      return DEEPTH'($urandom_range(0, WORDS - 1));
   endfunction

   // Monitor: one expected entry per clock edge, checked just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.ca) begin
               vectors++;
               if (read_data_A !== e.a) begin
                  miscompares++;
                  $display("FAIL read_data_A t=%0t got %h expected %h", $time, read_data_A, e.a);
               end
            end
            if (e.cb) begin
               vectors++;
               if (read_data_B !== e.b) begin
                  miscompares++;
                  $display("FAIL read_data_B t=%0t got %h expected %h", $time, read_data_B, e.b);
               end
            end
            vectors++;
            if (busy !== e.bz) begin
               miscompares++;
               $display("FAIL busy t=%0t got %b expected %b", $time, busy, e.bz);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         mem_m[i] = '0;
         known[i] = 1'b0;
      end
      rst = 1'b1; write_EN = 1'b0; write_addr = '0; write_data = '0;
      read_EN_A = 1'b0; read_addr_A = '0; read_EN_B = 1'b0; read_addr_B = '0;

      // Reset state straight after the first edge under reset
      @(posedge clk);
      #1;
      vectors++;
      if (read_data_A !== '0 || read_data_B !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got A=%h B=%h expected 00 00", read_data_A, read_data_B);
      end
`ifdef RAM_1W2R_CLEAR_EN
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_busy got %b expected 1", busy);
      end
`else
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy got %b expected 0", busy);
      end
`endif

      step(1'b1, 1'b0, '0, '0, 1'b1, '0, 1'b1, '0);
      step(1'b1, 1'b1, 8'h3C, 8'h77, 1'b1, 8'h3C, 1'b0, '0);
      // Writes during the clear sweep must be dropped
      step(1'b0, 1'b1, 8'h30, 8'hEE, 1'b1, 8'h30, 1'b0, '0);
      while (clear_left > 0) idle();
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h00, 1'b1, 8'h80);
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'hFF, 1'b1, 8'h30);

      // Write-through on the same edge
      step(1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1, 8'h3C, 1'b0, '0);
      // Buffer forward to both ports, then array read
      step(1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h10, 1'b1, 8'h10);
      idle();
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h10, 1'b1, 8'h10);
      // Back-to-back writes, same address then neighbour
      step(1'b0, 1'b1, 8'h20, 8'h11, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 8'h20, 8'h22, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 8'h21, 8'h33, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h20, 1'b1, 8'h21);
      idle();
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h20, 1'b0, '0);
      // Port A holds while B tracks a fresh write
      step(1'b0, 1'b1, 8'h55, 8'h99, 1'b0, 8'h55, 1'b1, 8'h3C);
      step(1'b0, 1'b0, '0, '0, 1'b0, 8'h10, 1'b1, 8'h55);
      // Top address, both ports on the same word as the write
      step(1'b0, 1'b1, 8'hFF, 8'h5C, 1'b1, 8'hFF, 1'b1, 8'hFF);
      // Reset before commit discards the buffered write
      step(1'b0, 1'b1, 8'h7F, 8'h44, 1'b0, '0, 1'b0, '0);
      idle();
      idle();
      step(1'b0, 1'b1, 8'h7F, 8'hC3, 1'b0, '0, 1'b0, '0);
      step(1'b1, 1'b0, '0, '0, 1'b1, 8'h7F, 1'b1, 8'h7F);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      while (clear_left > 0) idle();
      step(1'b0, 1'b0, '0, '0, 1'b1, 8'h7F, 1'b1, 8'h7F);

      // Randomised traffic concentrated on a few addresses for forwarding hits
      for (int n = 0; n < 2000; n++) begin
         logic r;
         r = ($urandom_range(0, 599) == 0) && (resets < 3);
         if (r) resets++;
         step(r, ($urandom_range(0, 1) == 1), rand_addr(), WIDTH'($urandom),
              ($urandom_range(0, 9) < 7), rand_addr(),
              ($urandom_range(0, 9) < 7), rand_addr());
      end
      idle();

      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d entries left expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
